// File: rtl/pe_simd.sv
// SIMD systolic processing element: per-beat dot product, tile accumulate, buffered drain chain.
// Define ACC_SAT_EN for a saturating accumulator; the default build wraps modulo 2^D_W_ACC.
module pe_simd #(
  parameter int unsigned D_W         = 8,
  parameter int unsigned D_W_ACC     = 32,
  parameter int unsigned LANES       = 2,
  parameter int unsigned SIGNED      = 0,
  parameter int unsigned DRAIN_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init,
  input  logic                 in_en,
  input  logic [LANES*D_W-1:0] in_a,
  input  logic [LANES*D_W-1:0] in_b,
  output logic [LANES*D_W-1:0] out_a,
  output logic [LANES*D_W-1:0] out_b,
  output logic                 out_en,
  output logic                 out_init,
  input  logic                 in_valid,
  input  logic [D_W_ACC-1:0]   in_data,
  output logic                 out_valid,
  output logic [D_W_ACC-1:0]   out_data,
  output logic                 ovf
);

  localparam int unsigned PW = 2 * D_W + $clog2(LANES);
  localparam int unsigned XW = ((PW > D_W_ACC) ? PW : D_W_ACC) + 2;
  localparam int unsigned AW = (DRAIN_DEPTH > 1) ? $clog2(DRAIN_DEPTH) : 1;
  localparam int unsigned CW = $clog2(DRAIN_DEPTH + 1);
  localparam logic SGN = (SIGNED != 0);
  localparam logic [AW-1:0] LAST = AW'(DRAIN_DEPTH - 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DRAIN_DEPTH);

  function automatic logic [PW-1:0] ext_op(input logic [D_W-1:0] v);
    return {{(PW - D_W){SGN & v[D_W-1]}}, v};
  endfunction

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + AW'(1);
  endfunction

  logic [LANES*D_W-1:0] a_q, b_q;
  logic                 en_q, init_fwd_q;
  logic [PW-1:0]        dot, p_q;
  logic                 init_q;
  logic [D_W_ACC-1:0]   acc_q, acc_d;
  logic [XW-1:0]        p_x;

  assign out_a    = a_q;
  assign out_b    = b_q;
  assign out_en   = en_q;
  assign out_init = init_fwd_q;

  // Extending operands to PW bits first makes the low PW product bits correct in both modes.
  always_comb begin
    dot = '0;
    for (int i = 0; i < LANES; i++) begin
      dot = dot + ext_op(in_a[i*D_W +: D_W]) * ext_op(in_b[i*D_W +: D_W]);
    end
  end

  assign p_x = {{(XW - PW){SGN & p_q[PW-1]}}, p_q};

`ifdef ACC_SAT_EN
  localparam logic [XW-1:0] HI = SGN ? {{(XW - D_W_ACC + 1){1'b0}}, {(D_W_ACC - 1){1'b1}}}
                                     : {{(XW - D_W_ACC){1'b0}}, {D_W_ACC{1'b1}}};
  localparam logic [XW-1:0] LO = SGN ? {{(XW - D_W_ACC + 1){1'b1}}, {(D_W_ACC - 1){1'b0}}}
                                     : '0;

  // XW leaves headroom, so a signed compare is exact for unsigned values too.
  function automatic logic [XW-1:0] clamp(input logic [XW-1:0] v);
    if ($signed(v) > $signed(HI)) return HI;
    if ($signed(v) < $signed(LO)) return LO;
    return v;
  endfunction

  logic          sat_q, sat_d;
  logic [XW-1:0] acc_x, p_c, s_x, s_c;
  logic          unused_hi;

  assign acc_x     = {{(XW - D_W_ACC){SGN & acc_q[D_W_ACC-1]}}, acc_q};
  assign unused_hi = ^{p_c[XW-1:D_W_ACC], s_c[XW-1:D_W_ACC]};

  always_comb begin
    p_c = clamp(p_x);
    s_x = acc_x + p_c;
    s_c = clamp(s_x);
    if (init_q) begin
      acc_d = p_c[D_W_ACC-1:0];
      sat_d = (p_c != p_x);
    end else if (sat_q) begin
      acc_d = acc_q;
      sat_d = 1'b1;
    end else begin
      acc_d = s_c[D_W_ACC-1:0];
      sat_d = (p_c != p_x) || (s_c != s_x);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) sat_q <= 1'b0;
    else      sat_q <= sat_d;
  end
`else
  logic unused_hi;
  assign unused_hi = ^p_x[XW-1:D_W_ACC];
  assign acc_d = init_q ? p_x[D_W_ACC-1:0] : acc_q + p_x[D_W_ACC-1:0];
`endif

  // Drain FIFO: up to two pushes (own result first) and one pop per edge.
  logic [D_W_ACC-1:0] mem [DRAIN_DEPTH];
  logic [AW-1:0]      wr_q, rd_q, wr1;
  logic [CW-1:0]      count_q;
  logic [CW:0]        free;
  logic               pop, own_ok, fwd_ok, drop;
  logic               valid_q, ovf_q;
  logic [D_W_ACC-1:0] data_q;

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign ovf       = ovf_q;

  always_comb begin
    pop    = (count_q != '0);
    free   = DEPTH_C - {1'b0, count_q} + {{CW{1'b0}}, pop};
    own_ok = init_q && (free != '0);
    fwd_ok = in_valid && (free > {{CW{1'b0}}, own_ok});
    drop   = (init_q && !own_ok) || (in_valid && !fwd_ok);
    wr1    = inc(wr_q);
  end

  always_ff @(posedge clk) begin
    if (own_ok) mem[wr_q] <= acc_q;
    if (fwd_ok) mem[own_ok ? wr1 : wr_q] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q        <= '0;
      b_q        <= '0;
      en_q       <= 1'b0;
      init_fwd_q <= 1'b0;
      p_q        <= '0;
      init_q     <= 1'b0;
      acc_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      a_q        <= in_a;
      b_q        <= in_b;
      en_q       <= in_en;
      init_fwd_q <= init;
      p_q        <= in_en ? dot : '0;
      init_q     <= init;
      acc_q      <= acc_d;
      if (own_ok && fwd_ok)      wr_q <= inc(wr1);
      else if (own_ok || fwd_ok) wr_q <= wr1;
      if (pop) begin
        rd_q   <= inc(rd_q);
        data_q <= mem[rd_q];
      end
      count_q <= count_q + CW'(own_ok) + CW'(fwd_ok) - CW'(pop);
      valid_q <= pop;
      ovf_q   <= ovf_q | drop;
    end
  end

endmodule

// File: tb/tb_pe_simd.sv
// Scoreboard bench for pe_simd: four instances (default, shallow drain, signed, 16-bit acc).
// Stimulus is gated per instance by sel; each output word is checked for value and cycle.
module tb_pe_simd;

  logic        clk = 1'b0;
  logic        rst;
  logic        init, in_en, in_valid;
  logic [15:0] in_a, in_b;
  logic [31:0] in_data;
  logic [3:0]  sel;

  logic [15:0] oa [4];
  logic [15:0] ob [4];
  logic        oen [4];
  logic        oin [4];
  logic        ov [4];
  logic        ovf_o [4];
  logic [31:0] od [4];
  logic [15:0] od3;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign od[3] = {16'h0000, od3};

  pe_simd u_dut0 (
    .clk(clk), .rst(rst), .init(init & sel[0]), .in_en(in_en & sel[0]),
    .in_a(in_a), .in_b(in_b), .out_a(oa[0]), .out_b(ob[0]), .out_en(oen[0]),
    .out_init(oin[0]), .in_valid(in_valid & sel[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_data(od[0]), .ovf(ovf_o[0])
  );

  pe_simd #(.DRAIN_DEPTH(2)) u_dut1 (
    .clk(clk), .rst(rst), .init(init & sel[1]), .in_en(in_en & sel[1]),
    .in_a(in_a), .in_b(in_b), .out_a(oa[1]), .out_b(ob[1]), .out_en(oen[1]),
    .out_init(oin[1]), .in_valid(in_valid & sel[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_data(od[1]), .ovf(ovf_o[1])
  );

  pe_simd #(.SIGNED(1)) u_dut2 (
    .clk(clk), .rst(rst), .init(init & sel[2]), .in_en(in_en & sel[2]),
    .in_a(in_a), .in_b(in_b), .out_a(oa[2]), .out_b(ob[2]), .out_en(oen[2]),
    .out_init(oin[2]), .in_valid(in_valid & sel[2]), .in_data(in_data),
    .out_valid(ov[2]), .out_data(od[2]), .ovf(ovf_o[2])
  );

  pe_simd #(.D_W_ACC(16)) u_dut3 (
    .clk(clk), .rst(rst), .init(init & sel[3]), .in_en(in_en & sel[3]),
    .in_a(in_a), .in_b(in_b), .out_a(oa[3]), .out_b(ob[3]), .out_en(oen[3]),
    .out_init(oin[3]), .in_valid(in_valid & sel[3]), .in_data(in_data[15:0]),
    .out_valid(ov[3]), .out_data(od3), .ovf(ovf_o[3])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_word(input int id, input logic [31:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    case (id)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  task automatic sb_pop(input int id, input logic [31:0] d);
    exp_t e;
    bit   have = 1'b0;
    case (id)
      0: if (q0.size() != 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() != 0) begin e = q1.pop_front(); have = 1'b1; end
      2: if (q2.size() != 0) begin e = q2.pop_front(); have = 1'b1; end
      default: if (q3.size() != 0) begin e = q3.pop_front(); have = 1'b1; end
    endcase
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL sb_dut%0d: got unexpected word %h at cycle %0d", id, d, cyc);
    end else if (d !== e.data || cyc != e.cyc) begin
      errors++;
      $display("FAIL sb_dut%0d: got %h at cycle %0d, expected %h at cycle %0d",
               id, d, cyc, e.data, e.cyc);
    end
  endtask

  // Monitor: every drain word from any instance must match the head of its queue.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 4; i++) begin
        if (ov[i] === 1'b1) sb_pop(i, od[i]);
      end
    end
  end

  task automatic drive(input logic i_init, input logic en, input logic [15:0] a,
                       input logic [15:0] b, input logic v, input logic [31:0] d);
    init     = i_init;
    in_en    = en;
    in_a     = a;
    in_b     = b;
    in_valid = v;
    in_data  = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 32'h0);
  endtask

  initial begin
    int c;
    logic [31:0] sat_exp;

    // Reset with random inputs on every instance
    rst = 1'b0;
    sel = 4'hF;
    for (int k = 0; k < 2; k++) begin
      drive(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), $urandom);
    end
    chk("rst_out_a", {16'h0, oa[0]}, 32'h0);
    chk("rst_out_b", {16'h0, ob[0]}, 32'h0);
    chk("rst_out_en", {31'h0, oen[0]}, 32'h0);
    chk("rst_out_init", {31'h0, oin[0]}, 32'h0);
    chk("rst_out_valid", {31'h0, ov[0]}, 32'h0);
    chk("rst_out_data", od[0], 32'h0);
    chk("rst_ovf", {31'h0, ovf_o[0]}, 32'h0);
    rst    = 1'b1;
    mon_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      idle(1);
      chk("idle_out_valid", {31'h0, ov[0]}, 32'h0);
    end

    // Basic tile: 4 beats of (1,2).(3,4) = 11 each
    sel = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, 16'h0201, 16'h0403, 1'b0, 32'h0);
      chk("fwd_a", {16'h0, oa[0]}, 32'h0201);
      chk("fwd_b", {16'h0, ob[0]}, 32'h0403);
      chk("fwd_en", {31'h0, oen[0]}, 32'h1);
    end
    drive(1'b0, 1'b0, 16'hA55A, 16'h3CC3, 1'b0, 32'h0);
    chk("fwd_a_noen", {16'h0, oa[0]}, 32'hA55A);
    chk("fwd_b_noen", {16'h0, ob[0]}, 32'h3CC3);
    chk("fwd_en_low", {31'h0, oen[0]}, 32'h0);
    c = cyc;
    expect_word(0, 32'd44, c + 3);
    drive(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 32'h0);
    chk("fwd_init", {31'h0, oin[0]}, 32'h1);
    idle(3);

    // Collision: own result then three upstream words
    drive(1'b0, 1'b1, 16'h0005, 16'h0002, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 16'h0005, 16'h0002, 1'b0, 32'h0);
    c = cyc;
    expect_word(0, 32'd20, c + 3);
    drive(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      expect_word(0, 32'd100 + 32'(k), c + 4 + k);
      drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 32'd100 + 32'(k));
    end
    idle(4);
    chk("collision_ovf", {31'h0, ovf_o[0]}, 32'h0);

    // Overflow on a 2-entry drain: upstream words 3 and 4 are dropped
    sel = 4'b0010;
    chk("ovf_before", {31'h0, ovf_o[1]}, 32'h0);
    c = cyc;
    expect_word(1, 32'd1,  c + 3);
    expect_word(1, 32'd11, c + 4);
    expect_word(1, 32'd2,  c + 5);
    expect_word(1, 32'd20, c + 6);
    expect_word(1, 32'd30, c + 7);
    expect_word(1, 32'd5,  c + 8);
    expect_word(1, 32'd6,  c + 9);
    drive(1'b0, 1'b1, 16'h0201, 16'h0403, 1'b0, 32'd0);
    drive(1'b1, 1'b1, 16'h000A, 16'h0002, 1'b1, 32'd1);
    drive(1'b1, 1'b1, 16'h000A, 16'h0003, 1'b1, 32'd2);
    drive(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 32'd3);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 32'd4);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 32'd5);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 32'd6);
    idle(4);
    chk("ovf_sticky", {31'h0, ovf_o[1]}, 32'h1);

    // Signed: (-3*5 + 2*7) = -1 per beat, three beats
    sel = 4'b0100;
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 16'h02FD, 16'h0705, 1'b0, 32'h0);
    c = cyc;
    expect_word(2, 32'hFFFF_FFFD, c + 3);
    drive(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 32'h0);
    idle(3);

    // 16-bit accumulator: 2*255*255 = 0x1FC02
`ifdef ACC_SAT_EN
    sat_exp = 32'h0000_FFFF;
`else
    sat_exp = 32'h0000_FC02;
`endif
    sel = 4'b1000;
    drive(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 32'h0);
    c = cyc;
    expect_word(3, sat_exp, c + 3);
    drive(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 32'h0);
    idle(4);

    chk("sb_empty_dut0", q0.size(), 32'h0);
    chk("sb_empty_dut1", q1.size(), 32'h0);
    chk("sb_empty_dut2", q2.size(), 32'h0);
    chk("sb_empty_dut3", q3.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
